// File: rtl/multicycle_control_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multicycle_control_if : controller <-> datapath control bundle
// Revision: 1.0
// ---------------------------------------------------------------------------
interface multicycle_control_if;
    logic [6:0] OpCode;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite;
    logic       PCSource;
    logic       IRWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       IorD;
    logic       RegWrite;
    logic       MemToReg;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic       InstrDone;
    logic       Trap;

    modport master (
        input  OpCode, Zero, MemReady,
        output PCWrite, PCSource, IRWrite, MemRead, MemWrite, IorD,
               RegWrite, MemToReg, ALUSrcA, ALUSrcB, ALUOp, InstrDone, Trap
    );

    modport slave (
        output OpCode, Zero, MemReady,
        input  PCWrite, PCSource, IRWrite, MemRead, MemWrite, IorD,
               RegWrite, MemToReg, ALUSrcA, ALUSrcB, ALUOp, InstrDone, Trap
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multicycle_control : multi-cycle RISC-V main control FSM with memory
// timeout and sticky trap. CONTROL_ITYPE_EN enables the I-type ALU path.
// Revision: 1.0
// ---------------------------------------------------------------------------
module multicycle_control #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 4
) (
    input  logic                clk,
    input  logic                rst,
    multicycle_control_if.master bus
);
    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_EXEC_R  = 4'd2;
    localparam logic [3:0] S_EXEC_I  = 4'd3;
    localparam logic [3:0] S_ALU_WB  = 4'd4;
    localparam logic [3:0] S_MEMADDR = 4'd5;
    localparam logic [3:0] S_MEMRD   = 4'd6;
    localparam logic [3:0] S_MEM_WB  = 4'd7;
    localparam logic [3:0] S_MEMWR   = 4'd8;
    localparam logic [3:0] S_BRANCH  = 4'd9;
    localparam logic [3:0] S_TRAP    = 4'd10;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_SD = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MEM_WAIT_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [3:0]       state;
    logic [3:0]       state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic             mem_state;
    logic             timeout;

    assign mem_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    // Ready in the same cycle as the limit still completes the access.
    assign timeout   = (MEM_WAIT_MAX > 0) && mem_state && !bus.MemReady
                       && (wait_cnt == WAIT_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                wait_cnt <= '0;
            end else if (mem_state && !bus.MemReady) begin
                wait_cnt <= wait_cnt + CNT_ONE;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH: begin
                if (bus.MemReady)  state_nxt = S_DECODE;
                else if (timeout)  state_nxt = S_TRAP;
            end
            S_DECODE: begin
                case (bus.OpCode)
                    OP_R:         state_nxt = S_EXEC_R;
                    OP_LD, OP_SD: state_nxt = S_MEMADDR;
                    OP_BR:        state_nxt = S_BRANCH;
`ifdef CONTROL_ITYPE_EN
                    OP_I:         state_nxt = S_EXEC_I;
`else
                    OP_I:         state_nxt = S_TRAP;
`endif
                    default:      state_nxt = S_TRAP;
                endcase
            end
            S_EXEC_R:  state_nxt = S_ALU_WB;
            S_EXEC_I:  state_nxt = S_ALU_WB;
            S_ALU_WB:  state_nxt = S_FETCH;
            S_MEMADDR: state_nxt = (bus.OpCode == OP_LD) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (bus.MemReady)  state_nxt = S_MEM_WB;
                else if (timeout)  state_nxt = S_TRAP;
            end
            S_MEM_WB:  state_nxt = S_FETCH;
            S_MEMWR: begin
                if (bus.MemReady)  state_nxt = S_FETCH;
                else if (timeout)  state_nxt = S_TRAP;
            end
            S_BRANCH:  state_nxt = S_FETCH;
            S_TRAP:    state_nxt = S_TRAP;
            default:   state_nxt = S_TRAP;
        endcase
    end

    // Outputs are held low while rst is asserted so an aborted instruction
    // never issues a late write.
    always_comb begin
        bus.PCWrite   = 1'b0;
        bus.PCSource  = 1'b0;
        bus.IRWrite   = 1'b0;
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.IorD      = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.MemToReg  = 1'b0;
        bus.ALUSrcA   = 1'b0;
        bus.ALUSrcB   = 2'b00;
        bus.ALUOp     = 2'b00;
        bus.InstrDone = 1'b0;
        bus.Trap      = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    bus.MemRead = 1'b1;
                    bus.ALUSrcB = 2'b01;
                    bus.IRWrite = bus.MemReady;
                    bus.PCWrite = bus.MemReady;
                end
                S_DECODE: bus.ALUSrcB = 2'b10;
                S_EXEC_R: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUOp   = 2'b10;
                end
                S_EXEC_I: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = 2'b10;
                    bus.ALUOp   = 2'b11;
                end
                S_ALU_WB: begin
                    bus.RegWrite  = 1'b1;
                    bus.InstrDone = 1'b1;
                end
                S_MEMADDR: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = 2'b10;
                end
                S_MEMRD: begin
                    bus.MemRead = 1'b1;
                    bus.IorD    = 1'b1;
                end
                S_MEM_WB: begin
                    bus.RegWrite  = 1'b1;
                    bus.MemToReg  = 1'b1;
                    bus.InstrDone = 1'b1;
                end
                S_MEMWR: begin
                    bus.MemWrite  = 1'b1;
                    bus.IorD      = 1'b1;
                    bus.InstrDone = bus.MemReady;
                end
                S_BRANCH: begin
                    bus.ALUSrcA   = 1'b1;
                    bus.ALUOp     = 2'b01;
                    bus.PCSource  = 1'b1;
                    bus.PCWrite   = bus.Zero;
                    bus.InstrDone = 1'b1;
                end
                S_TRAP:  bus.Trap = 1'b1;
                default: bus.Trap = 1'b0;
            endcase
        end
    end
endmodule
`default_nettype wire
